// File: rtl/rhythm_lane_judge.sv
// Multi-lane rhythm judge: note FIFO, per-note hit window tracking, score/combo accumulation.
// Optional JUDGE_STATS_EN adds saturating perfect/good/miss counters.
module rhythm_lane_judge #(
    parameter int LANES       = 8,
    parameter int TIME_W      = 10,
    parameter int DEPTH       = 8,
    parameter int PERFECT_WIN = 2,
    parameter int GOOD_WIN    = 5,
    parameter int SCORE_W     = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [TIME_W-1:0]  now,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic [TIME_W-1:0]  note_time,
    input  logic [LANES-1:0]   note_lanes,
    input  logic [LANES-1:0]   key,
    output logic               judge_valid,
    output logic [1:0]         judge_result,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo
`ifdef JUDGE_STATS_EN
    ,
    output logic [SCORE_W-1:0] perfect_cnt,
    output logic [SCORE_W-1:0] good_cnt,
    output logic [SCORE_W-1:0] miss_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RES_MISS    = 2'd0;
    localparam logic [1:0] RES_GOOD    = 2'd1;
    localparam logic [1:0] RES_PERFECT = 2'd2;
    localparam logic [SCORE_W-1:0] SAT = '1;
    localparam logic signed [TIME_W-1:0] G_HI = TIME_W'(GOOD_WIN);
    localparam logic signed [TIME_W-1:0] G_LO = -G_HI;
    localparam logic signed [TIME_W-1:0] P_HI = TIME_W'(PERFECT_WIN);
    localparam logic signed [TIME_W-1:0] P_LO = -P_HI;

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_OPEN, S_JUDGE} state_t;

    state_t state, state_nx;

    logic [TIME_W-1:0] q_time  [DEPTH];
    logic [LANES-1:0]  q_lanes [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nx;
    logic              alive;

    logic [LANES-1:0]  key_q, hit, take, pending, pending_nx;
    logic              imperfect, imperfect_nx;
    logic signed [TIME_W-1:0] delta;
    logic              push, store, pop, in_win, finish;
    logic [1:0]        result_nx;
    logic [SCORE_W-1:0] score_nx, combo_nx;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W+1)'(b);
        return s[SCORE_W] ? SAT : s[SCORE_W-1:0];
    endfunction

    // alive keeps note_ready low while reset is asserted
    assign note_ready = alive & (count != (AW+1)'(DEPTH));
    assign push       = note_valid & note_ready;
    assign store      = push & (|note_lanes);
    assign pop        = (state == S_JUDGE);
    assign count_nx   = count + (AW+1)'(store) - (AW+1)'(pop);

    // modulo difference read as signed makes wrap of now transparent
    assign delta  = now - q_time[rd_ptr];
    assign in_win = (delta >= G_LO) && (delta <= G_HI);
    assign hit    = key & ~key_q;

    always_comb begin
        take         = '0;
        imperfect_nx = imperfect;
        if (state == S_OPEN && in_win) begin
            take = hit & pending;
            if ((|take) && (delta > P_HI || delta < P_LO))
                imperfect_nx = 1'b1;
        end
        pending_nx = pending & ~take;
        finish     = (state == S_OPEN) && ((pending_nx == '0) || (delta > G_HI));
        if (pending_nx != '0)
            result_nx = RES_MISS;
        else if (imperfect_nx)
            result_nx = RES_GOOD;
        else
            result_nx = RES_PERFECT;
    end

    always_comb begin
        score_nx = score;
        combo_nx = '0;
        case (result_nx)
            RES_PERFECT: begin
                score_nx = sat_add(score, 2'd2);
                combo_nx = sat_add(combo, 2'd1);
            end
            RES_GOOD: begin
                score_nx = sat_add(score, 2'd1);
                combo_nx = sat_add(combo, 2'd1);
            end
            default: combo_nx = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY: if (count != '0) state_nx = S_WAIT;
            S_WAIT:  if (delta >= G_LO) state_nx = S_OPEN;
            S_OPEN:  if (finish) state_nx = S_JUDGE;
            S_JUDGE: state_nx = (count_nx != '0) ? S_WAIT : S_EMPTY;
            default: state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_EMPTY;
        else if (clear)
            state <= S_EMPTY;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (store && !clear) begin
            q_time[wr_ptr]  <= note_time;
            q_lanes[wr_ptr] <= note_lanes;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            alive  <= 1'b0;
            key_q  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            alive  <= 1'b1;
            key_q  <= '0;
        end else begin
            alive <= 1'b1;
            key_q <= key;
            count <= count_nx;
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // judgement is registered on the finishing OPEN cycle so it is visible during JUDGE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            imperfect    <= 1'b0;
            judge_valid  <= 1'b0;
            judge_result <= RES_MISS;
            score        <= '0;
            combo        <= '0;
            max_combo    <= '0;
        end else if (clear) begin
            pending      <= '0;
            imperfect    <= 1'b0;
            judge_valid  <= 1'b0;
            judge_result <= RES_MISS;
            score        <= '0;
            combo        <= '0;
            max_combo    <= '0;
        end else begin
            judge_valid <= finish;
            if (state == S_WAIT) begin
                pending   <= q_lanes[rd_ptr];
                imperfect <= 1'b0;
            end else if (state == S_OPEN) begin
                pending   <= pending_nx;
                imperfect <= imperfect_nx;
            end
            if (finish) begin
                judge_result <= result_nx;
                score        <= score_nx;
                combo        <= combo_nx;
                if (combo_nx > max_combo) max_combo <= combo_nx;
            end
        end
    end

`ifdef JUDGE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perfect_cnt <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
        end else if (clear) begin
            perfect_cnt <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
        end else if (finish) begin
            case (result_nx)
                RES_PERFECT: perfect_cnt <= sat_add(perfect_cnt, 2'd1);
                RES_GOOD:    good_cnt    <= sat_add(good_cnt, 2'd1);
                default:     miss_cnt    <= sat_add(miss_cnt, 2'd1);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rhythm_lane_judge.sv
// Scoreboard bench for rhythm_lane_judge: directed scenarios plus randomized note/key streams
// judged by a per-note window model; a monitor pops expectations on judge_valid.
module tb_rhythm_lane_judge;
    localparam int LANES = 8;
    localparam int TW    = 10;
    localparam int GW    = 5;
    localparam int PW    = 2;
    localparam int SW    = 6;
    localparam int SMAX  = 63;
    localparam int N     = 100;
    localparam int A0    = 900;
    localparam int TOTAL = 60 + 20 * N + 40;

    logic clock = 1'b0, reset_n = 1'b0, clear = 1'b0;
    logic [TW-1:0] now = '0, note_time = '0;
    logic note_valid = 1'b0, note_ready;
    logic [LANES-1:0] note_lanes = '0, key = '0;
    logic judge_valid;
    logic [1:0] judge_result;
    logic [SW-1:0] score, combo, max_combo;
`ifdef JUDGE_STATS_EN
    logic [SW-1:0] perfect_cnt, good_cnt, miss_cnt;
`endif

    rhythm_lane_judge #(.LANES(LANES), .TIME_W(TW), .DEPTH(8), .PERFECT_WIN(PW),
                        .GOOD_WIN(GW), .SCORE_W(SW)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .now(now),
        .note_valid(note_valid), .note_ready(note_ready), .note_time(note_time),
        .note_lanes(note_lanes), .key(key), .judge_valid(judge_valid),
        .judge_result(judge_result), .score(score), .combo(combo), .max_combo(max_combo)
`ifdef JUDGE_STATS_EN
        , .perfect_cnt(perfect_cnt), .good_cnt(good_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int res; int score; int combo; int maxc; int pc; int gc; int mc; int when;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0;
    int m_score, m_combo, m_max, m_pc, m_gc, m_mc;
    logic [LANES-1:0] kmap [int];
    logic [LANES-1:0] kbase = '0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_max = 0; m_pc = 0; m_gc = 0; m_mc = 0;
    endtask

    // res: 0 MISS, 1 GOOD, 2 PERFECT; when = absolute game time of the judge_valid cycle
    task automatic model_judge(input int res, input int when);
        exp_t e;
        if (res == 2) begin
            m_score = sat(m_score + 2); m_combo = sat(m_combo + 1); m_pc = sat(m_pc + 1);
        end else if (res == 1) begin
            m_score = sat(m_score + 1); m_combo = sat(m_combo + 1); m_gc = sat(m_gc + 1);
        end else begin
            m_combo = 0; m_mc = sat(m_mc + 1);
        end
        if (m_combo > m_max) m_max = m_combo;
        e.res = res; e.score = m_score; e.combo = m_combo; e.maxc = m_max;
        e.pc = m_pc; e.gc = m_gc; e.mc = m_mc; e.when = when % 1024;
        sbq.push_back(e);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n && judge_valid) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_judge now=%0d result=%0d required=none", now, judge_result);
            end else begin
                e = sbq.pop_front();
                chk("judge_time", int'(now), e.when);
                chk("result", int'(judge_result), e.res);
                chk("score", int'(score), e.score);
                chk("combo", int'(combo), e.combo);
                chk("max_combo", int'(max_combo), e.maxc);
`ifdef JUDGE_STATS_EN
                chk("perfect_cnt", int'(perfect_cnt), e.pc);
                chk("good_cnt", int'(good_cnt), e.gc);
                chk("miss_cnt", int'(miss_cnt), e.mc);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        model_reset();
    endtask

    task automatic push_note(input int t, input int l);
        key = kbase;
        note_valid = 1'b1; note_time = TW'(t % 1024); note_lanes = LANES'(l);
        tick();
        note_valid = 1'b0;
    endtask

    task automatic run(input int from, input int to);
        for (int n = from; n <= to; n++) begin
            now = TW'(n % 1024);
            key = kbase | (kmap.exists(n) ? kmap[n] : '0);
            tick();
        end
        key = kbase;
    endtask

    int na [N];
    int nl [N];
    int rres [N];
    int rwhen [N];
    logic [LANES-1:0] ks [TOTAL];

    initial begin
        model_reset();
        #2;
        chk("rst_judge_valid", int'(judge_valid), 0);
        chk("rst_result", int'(judge_result), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_max_combo", int'(max_combo), 0);
        chk("rst_note_ready", int'(note_ready), 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", int'(note_ready), 1);

        // single lane, perfect hit
        kmap.delete(); now = 90; push_note(100, 8'h01);
        kmap[101] = 8'h01; model_judge(2, 102); run(91, 110);

        // two lanes, one early beyond the perfect window
        do_clear(); kmap.delete(); now = 90; push_note(100, 8'h05);
        kmap[96] = 8'h01; kmap[99] = 8'h04; model_judge(1, 100); run(91, 110);

        // partial hit times out: combo drops, max_combo kept
        kmap.delete(); now = 90; push_note(100, 8'h03);
        kmap[100] = 8'h01; model_judge(0, 107); run(91, 112);

        // note across the time wrap
        do_clear(); kmap.delete(); now = 1010; push_note(1022, 8'h80);
        kmap[1024] = 8'h80; model_judge(2, 1025); run(1011, 1040);

        // fill FIFO, ninth push must be dropped
        kmap.delete(); now = 150;
        for (int i = 0; i < 8; i++) push_note(200 + 10 * i, 1 << i);
        chk("full_not_ready", int'(note_ready), 0);
        note_valid = 1'b1; note_time = TW'(280); note_lanes = 8'hFF; tick(); note_valid = 1'b0;
        for (int i = 0; i < 8; i++) model_judge(0, 207 + 10 * i);
        run(151, 300);
        chk("drain_full", sbq.size(), 0);

        // clear flushes queued notes and discards a simultaneous push
        kmap.delete(); now = 300; push_note(320, 8'h01);
        note_valid = 1'b1; note_time = TW'(330); note_lanes = 8'h02; clear = 1'b1;
        tick();
        clear = 1'b0; note_valid = 1'b0; model_reset();
        chk("clr_score", int'(score), 0);
        chk("clr_combo", int'(combo), 0);
        chk("clr_max_combo", int'(max_combo), 0);
        chk("clr_note_ready", int'(note_ready), 1);
        kmap[320] = 8'h01; kmap[330] = 8'h02; run(301, 345);

        // head already past its window
        kmap.delete(); now = 100; push_note(50, 8'h01);
        model_judge(0, 104); run(101, 110);

        // held key gives no edge; stray edges on other lanes ignored
        do_clear(); kmap.delete(); kbase = 8'h08; now = 90; push_note(100, 8'h08);
        kmap[99] = 8'h10; kmap[101] = 8'h10; model_judge(0, 107); run(91, 110);
        kbase = '0; key = '0; tick();
        chk("drain_directed", sbq.size(), 0);

        // randomized stream, each note judged from its own window
        do_clear();
        for (int c = 0; c < TOTAL; c++) ks[c] = '0;
        for (int k = 0; k < N; k++) begin
            int pend, imp, last, l, d;
            na[k] = A0 + 60 + 20 * k;
            if ($urandom_range(0, 9) == 0) l = 0;
            else begin
                l = int'($urandom & $urandom & 32'hFF);
                if (l == 0) l = 1 << $urandom_range(0, 7);
            end
            nl[k] = l; pend = l; imp = 0; last = -100;
            for (int b = 0; b < LANES; b++) begin
                if (l[b]) begin
                    int r;
                    r = int'($urandom_range(0, 19));
                    if (r < 18) d = int'($urandom_range(0, 9)) - 4;
                    else if (r == 18) d = -GW - 2;
                    else d = GW + 1;
                    ks[na[k] - A0 + d][b] = 1'b1;
                    if (d >= -GW && d <= GW) begin
                        pend[b] = 1'b0;
                        if (d > PW || d < -PW) imp = 1;
                        if (d > last) last = d;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    d = int'($urandom_range(0, 9)) - 4;
                    ks[na[k] - A0 + d][b] = 1'b1;
                end
            end
            rres[k]  = (pend != 0) ? 0 : (imp != 0) ? 1 : 2;
            rwhen[k] = (pend != 0) ? na[k] + GW + 2 : na[k] + last + 1;
        end
        begin
            int nxt;
            nxt = 0;
            for (int c = 0; c < TOTAL; c++) begin
                now = TW'((A0 + c) % 1024);
                key = ks[c];
                if (nxt < N && na[nxt] - 60 <= A0 + c) begin
                    chk("rand_note_ready", int'(note_ready), 1);
                    note_valid = 1'b1;
                    note_time  = TW'(na[nxt] % 1024);
                    note_lanes = LANES'(nl[nxt]);
                    if (nl[nxt] != 0) model_judge(rres[nxt], rwhen[nxt]);
                    nxt++;
                end
                tick();
                note_valid = 1'b0;
            end
        end
        key = '0;
        repeat (5) tick();
        chk("drain_random", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
